disp_scan: RTL and testbench
============================

# disp_scan

Two-digit seven-segment scan driver. It consumes the packed BCD tens/units byte from the binary-to-BCD stage and drives both digits of the display by time-multiplexing the anodes, so the board no longer needs a manual tens/units select button. It includes its own BCD-to-segment decoder, optional leading-zero blanking, an invalid-digit flag, and an anti-ghosting blank window at every digit switch.

## Interface

- `REFRESH_DIV`, default 50000: clock cycles per digit slot; legal range ≥ 2.
- `BLANK_CYC`, default 500: cycles at the start of each slot with both anodes off; legal range 0 ≤ BLANK_CYC < REFRESH_DIV.
- `CNT_W`, default 16: width of the slot counter; must satisfy 2^CNT_W ≥ REFRESH_DIV.
- `clk`, input, 1: single system clock, rising edge.
- `rst_n`, input, 1: reset, synchronous, active-low.
- `bcd_in`, input, 8: [7:4] tens, [3:0] units, BCD.
- `load`, input, 1: capture strobe for `bcd_in`.
- `blank_lz`, input, 1: 1 suppresses a zero tens digit.
- `seg_n`, output, 7: {a,b,c,d,e,f,g}, active-low, registered.
- `an0`, output, 1: units anode, active-low, registered.
- `an1`, output, 1: tens anode, active-low, registered.
- `bcd_err`, output, 1: 1 while either captured nibble is greater than 9, registered.

## Operation

- **Capture register `disp_q[7:0]`.** On a rising edge with `load`=1 it takes `bcd_in`; otherwise it holds. `load` may be held high, in which case it samples every cycle.
- **Slot counter `cnt`.** Counts 0..REFRESH_DIV-1. At REFRESH_DIV-1 it wraps to 0, and on that same edge the FSM toggles.
- **FSM states.**
  - UNITS: selects `disp_q[3:0]` and `an0`.
  - TENS: selects `disp_q[7:4]` and `an1`.
  - Transitions: UNITS→TENS→UNITS, only on counter wrap. No other transitions.
- **Blank window.** While `cnt` < BLANK_CYC, `an0`=`an1`=1 and `seg_n`=7'h7F.
- **Active window.** When `cnt` ≥ BLANK_CYC:
  - The selected anode is 0 and the other anode is 1.
  - `seg_n` = decode(selected nibble).
- **Leading-zero blanking.** In TENS, if `blank_lz`=1 and `disp_q[7:4]`=0, then `an1` stays 1 and `seg_n` stays 7'h7F for the entire slot. Units are never blanked, so 00 displays as "0".
- **Decode table (a..g, active-low).**
  - 0 = 0000001
  - 1 = 1001111
  - 2 = 0010010
  - 3 = 0000110
  - 4 = 1001100
  - 5 = 0100100
  - 6 = 0100000
  - 7 = 0001111
  - 8 = 0000000
  - 9 = 0000100
  - 10..15 = 1111111 (blank)
- **Invalid digits.** `bcd_err` = (`disp_q[7:4]` > 9) | (`disp_q[3:0]` > 9). Its value is independent of the scan state.
- **Guaranteed exclusivity.** `an0` and `an1` are never both 0 in any cycle.

## Timing

- **Reset.** With `rst_n`=0 at an edge, the following take effect at that edge:
  - `disp_q`=0, `cnt`=0, state=UNITS.
  - `seg_n`=7'h7F, `an0`=1, `an1`=1, `bcd_err`=0.
  - Reset mid-slot or mid-blank aborts immediately. There is no partial-slot carry-over.
- **Output latency.** Outputs are registered from (state, `cnt`, `disp_q`). A pin value at edge k+1 reflects the internal values after edge k.
- **Load latency.** With `load`=1 sampled at edge k, `disp_q` updates at edge k. The new digit appears on `seg_n` at edge k+1 if that digit's slot is in its active window. `bcd_err` also updates at edge k+1.
- **First cycles after reset release.** The first cycle after release is `cnt`=0 in UNITS. The first `an0`=0 occurs BLANK_CYC+1 edges after release.
- **Boundary cases.**
  - BLANK_CYC=0: no blank window.
  - A `load` coinciding with the counter wrap: the new data and the new state take effect together.
  - A `blank_lz` change takes effect on the next registered output. There is no synchronizer; the caller provides synchronous inputs.
- **Scan period.** 2·REFRESH_DIV cycles per full refresh. With the defaults at 100 MHz that is about 1 kHz per digit.

## Test plan

All scenarios use REFRESH_DIV=8, BLANK_CYC=2.

- **Reset.** Hold `rst_n`=0 for 3 cycles, then release.
  - Outputs are 7F/1/1/0 during reset.
  - `an0` first goes low 3 edges after release.
  - The pattern is `an0` low for 6 cycles, both high for 2, `an1` low for 6, repeating with period 16.
- **Normal display.** `load` pulse with `bcd_in`=8'h47, `blank_lz`=0.
  - UNITS active window: `seg_n`=0001111.
  - TENS active window: `seg_n`=1001100.
  - `bcd_err`=0.
  - `an0`&`an1` never both 0 across 100 cycles.
- **Leading zero.** `bcd_in`=8'h05 with `blank_lz`=1.
  - TENS slot: `an1`=1 and `seg_n`=7F throughout.
  - Units shows 0100100.
  - With `blank_lz`=0, tens shows 0000001.
  - `bcd_in`=8'h00 with `blank_lz`=1: units still shows 0000001.
- **Invalid BCD.** Load 8'h1C.
  - `bcd_err`=1 one edge after load.
  - Units segments are 7F while `an0`=0.
  - Tens shows 1001111.
  - Then load 8'h19: `bcd_err` returns to 0.
- **Load at wrap and mid-slot reset.**
  - Pulse `load` with 8'h92 on the cycle where `cnt`=7 in UNITS. The following TENS active window shows 0000100.
  - Assert `rst_n`=0 for 1 cycle at `cnt`=4: the next edge shows outputs 7F/1/1, and the scan restarts in UNITS.

Source files
------------

// File: rtl/disp_scan_if.sv
// Display-side bundle for disp_scan: captured BCD input, strobes and the
// multiplexed seven-segment / anode pins.
interface disp_scan_if;
    logic [7:0] bcd_in;
    logic       load;
    logic       blank_lz;
    logic [6:0] seg_n;
    logic       an0;
    logic       an1;
    logic       bcd_err;

    modport master (
        output bcd_in, load, blank_lz,
        input  seg_n, an0, an1, bcd_err
    );

    modport slave (
        input  bcd_in, load, blank_lz,
        output seg_n, an0, an1, bcd_err
    );
endinterface

// File: rtl/disp_scan.sv
// Two-digit seven-segment scan driver: time-multiplexes units/tens anodes with
// a blank window at each digit switch, leading-zero blanking and a BCD error flag.
module disp_scan #(
    parameter int REFRESH_DIV = 50000,
    parameter int BLANK_CYC   = 500,
    parameter int CNT_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    disp_scan_if.slave  bus
);

    typedef enum logic {S_UNITS = 1'b0, S_TENS = 1'b1} state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [6:0]       SEG_OFF  = 7'h7F;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [7:0]       r_disp;
    logic [6:0]       r_seg_n;
    logic             r_an0;
    logic             r_an1;
    logic             r_bcd_err;

    logic             w_wrap;
    logic             w_active;
    logic             w_lz;
    logic             w_show;
    logic [3:0]       w_nib;
    logic [6:0]       w_seg_nxt;
    logic             w_an0_nxt;
    logic             w_an1_nxt;
    logic             w_err_nxt;

    // Segment order {a,b,c,d,e,f,g}, active-low; non-BCD codes go dark.
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b0000001;
            4'd1:    seg = 7'b1001111;
            4'd2:    seg = 7'b0010010;
            4'd3:    seg = 7'b0000110;
            4'd4:    seg = 7'b1001100;
            4'd5:    seg = 7'b0100100;
            4'd6:    seg = 7'b0100000;
            4'd7:    seg = 7'b0001111;
            4'd8:    seg = 7'b0000000;
            4'd9:    seg = 7'b0000100;
            default: seg = 7'b1111111;
        endcase
        return seg;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_UNITS;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_disp <= 8'h00;
        end else if (bus.load) begin
            r_disp <= bus.bcd_in;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_wrap      = (r_cnt == CNT_LAST);
        w_cnt_nxt   = w_wrap ? '0 : r_cnt + CNT_W'(1);
        if (w_wrap) begin
            w_state_nxt = (r_state == S_UNITS) ? S_TENS : S_UNITS;
        end

        // Signed compare keeps BLANK_CYC=0 well-defined (always active).
        w_active  = (int'(r_cnt) >= BLANK_CYC);
        w_nib     = (r_state == S_TENS) ? r_disp[7:4] : r_disp[3:0];
        w_lz      = (r_state == S_TENS) && bus.blank_lz && (r_disp[7:4] == 4'd0);
        w_show    = w_active && !w_lz;

        w_seg_nxt = w_show ? seg_decode(w_nib) : SEG_OFF;
        w_an0_nxt = !(w_show && (r_state == S_UNITS));
        w_an1_nxt = !(w_show && (r_state == S_TENS));
        w_err_nxt = (r_disp[7:4] > 4'd9) || (r_disp[3:0] > 4'd9);
    end

    // Anodes derive from a single state bit, so both can never be low together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_seg_n   <= SEG_OFF;
            r_an0     <= 1'b1;
            r_an1     <= 1'b1;
            r_bcd_err <= 1'b0;
        end else begin
            r_seg_n   <= w_seg_nxt;
            r_an0     <= w_an0_nxt;
            r_an1     <= w_an1_nxt;
            r_bcd_err <= w_err_nxt;
        end
    end

    assign bus.seg_n   = r_seg_n;
    assign bus.an0     = r_an0;
    assign bus.an1     = r_an1;
    assign bus.bcd_err = r_bcd_err;

endmodule

// File: tb/tb_disp_scan.sv
// Directed bench for disp_scan with REFRESH_DIV=8, BLANK_CYC=2.
module tb_disp_scan;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;
    int   ph;

    disp_scan_if bus ();

    disp_scan #(
        .REFRESH_DIV (8),
        .BLANK_CYC   (2),
        .CNT_W       (4)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h (ph=%0d)", tag, obs, exp, ph);
        end
    endtask

    // Advance one edge; ph is the scan position the outputs now reflect.
    task automatic step();
        @(posedge clk);
        #1;
        ph++;
    endtask

    // Expected pins from the 16-cycle pattern: 0..7 units slot, 8..15 tens slot,
    // first two cycles of each slot blank.
    task automatic chk_scan(input string tag, input logic [6:0] us, input logic [6:0] ts,
                            input logic tblank);
        int         s;
        logic       units;
        logic       act;
        logic       e_an0;
        logic       e_an1;
        logic [6:0] e_seg;
        s      = ph % 16;
        units  = (s < 8);
        act    = ((s % 8) >= 2);
        e_an0  = !(units && act);
        e_an1  = !(!units && act && !tblank);
        e_seg  = (!e_an0) ? us : (!e_an1) ? ts : 7'h7F;
        chk({tag, "_an0"}, 32'(bus.an0), 32'(e_an0));
        chk({tag, "_an1"}, 32'(bus.an1), 32'(e_an1));
        chk({tag, "_seg"}, 32'(bus.seg_n), 32'(e_seg));
        chk({tag, "_excl"}, 32'(!bus.an0 && !bus.an1), 32'd0);
    endtask

    task automatic load_byte(input logic [7:0] b);
        bus.bcd_in = b;
        bus.load   = 1'b1;
        step();
        bus.load   = 1'b0;
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        ph           = -1;
        rst_n        = 1'b0;
        bus.bcd_in   = 8'h00;
        bus.load     = 1'b0;
        bus.blank_lz = 1'b0;

        // Reset held three cycles
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_seg", 32'(bus.seg_n), 32'h7F);
            chk("rst_an0", 32'(bus.an0), 32'd1);
            chk("rst_an1", 32'(bus.an1), 32'd1);
            chk("rst_err", 32'(bus.bcd_err), 32'd0);
        end
        rst_n = 1'b1;
        ph    = -1;

        step();
        chk("rel1_an0", 32'(bus.an0), 32'd1);
        step();
        chk("rel2_an0", 32'(bus.an0), 32'd1);
        step();
        chk("rel3_an0", 32'(bus.an0), 32'd0);
        for (int i = 0; i < 32; i++) begin
            step();
            chk_scan("pat0", 7'h01, 7'h01, 1'b0);
        end

        // Normal display 47
        load_byte(8'h47);
        step();
        for (int i = 0; i < 100; i++) begin
            step();
            chk_scan("d47", 7'h0F, 7'h4C, 1'b0);
            chk("d47_err", 32'(bus.bcd_err), 32'd0);
        end

        // Leading zero blanking
        bus.blank_lz = 1'b1;
        load_byte(8'h05);
        step();
        for (int i = 0; i < 32; i++) begin
            step();
            chk_scan("lz05", 7'h24, 7'h01, 1'b1);
        end
        bus.blank_lz = 1'b0;
        step();
        for (int i = 0; i < 16; i++) begin
            step();
            chk_scan("nolz05", 7'h24, 7'h01, 1'b0);
        end
        bus.blank_lz = 1'b1;
        load_byte(8'h00);
        step();
        for (int i = 0; i < 16; i++) begin
            step();
            chk_scan("lz00", 7'h01, 7'h01, 1'b1);
        end
        bus.blank_lz = 1'b0;

        // Invalid BCD; error flag lags the load by one edge
        load_byte(8'h1C);
        chk("err_lag", 32'(bus.bcd_err), 32'd0);
        step();
        chk("err_set", 32'(bus.bcd_err), 32'd1);
        for (int i = 0; i < 16; i++) begin
            step();
            chk_scan("bad1C", 7'h7F, 7'h4F, 1'b0);
            chk("bad1C_err", 32'(bus.bcd_err), 32'd1);
        end
        load_byte(8'h19);
        chk("err_hold", 32'(bus.bcd_err), 32'd1);
        step();
        chk("err_clr", 32'(bus.bcd_err), 32'd0);

        // Load coinciding with the units->tens wrap
        while (((ph + 1) % 16) != 7) step();
        load_byte(8'h92);
        for (int i = 0; i < 24; i++) begin
            step();
            chk_scan("wrap92", 7'h12, 7'h04, 1'b0);
        end

        // One-cycle reset at cnt=4 in the units slot
        while (((ph + 1) % 16) != 4) step();
        rst_n = 1'b0;
        step();
        chk("mrst_seg", 32'(bus.seg_n), 32'h7F);
        chk("mrst_an0", 32'(bus.an0), 32'd1);
        chk("mrst_an1", 32'(bus.an1), 32'd1);
        chk("mrst_err", 32'(bus.bcd_err), 32'd0);
        rst_n = 1'b1;
        ph    = -1;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_scan("restart", 7'h01, 7'h01, 1'b0);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
